stl_dispatch: RTL and testbench



---
 rtl/stl_dispatch.sv | 164 ++++++++++++++++
 tb/tb_stl_dispatch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/stl_dispatch.sv
// stl_dispatch: credit-based scatter. One valid/ready input stream is delivered to
// exactly one of DST_N destinations. The item goes to a destination that the per-item
// mask enables and that holds a credit. TYPE sets the selection policy.
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   vld_i      input item valid
//   rdy_o      input ready (combinational from credit registers and msk_i)
//   dat_i      input payload
//   msk_i      destinations allowed for this item
//   vld_o      registered one-hot (or zero) valid per destination
//   dat_o      registered payload, shared by all destinations
//   idx_o      registered index of the destination pulsed in vld_o
//   crd_rtn_i  per-destination credit return, one credit per bit per cycle
//   crd_o      packed current credit count per destination
//   err_o      sticky: credit returned while the counter is already full
module stl_dispatch #(
  parameter string       TYPE    = "FSTL",
  parameter int unsigned DST_N   = 16,
  parameter int unsigned DST_NW  = 4,
  parameter int unsigned DAT_DW  = 32,
  parameter int unsigned CRD_MAX = 4,
  parameter int unsigned CRD_W   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_i,
  output logic                     rdy_o,
  input  logic [DAT_DW-1:0]        dat_i,
  input  logic [DST_N-1:0]         msk_i,
  output logic [DST_N-1:0]         vld_o,
  output logic [DAT_DW-1:0]        dat_o,
  output logic [DST_NW-1:0]        idx_o,
  input  logic [DST_N-1:0]         crd_rtn_i,
  output logic [DST_N*CRD_W-1:0]   crd_o,
  output logic                     err_o
);

  logic [CRD_W-1:0]  crd_q [DST_N];
  logic [CRD_W-1:0]  crd_d [DST_N];
  logic [DST_N-1:0]  elig;
  logic [DST_NW-1:0] sel;
  logic [DST_NW-1:0] ptr_q, ptr_d;
  logic [DST_N-1:0]  vld_q, vld_d;
  logic [DAT_DW-1:0] dat_q;
  logic [DST_NW-1:0] idx_q;
  logic              err_q, err_d;
  logic              accept;

  // Eligibility uses registered credits only, so a return is usable next cycle.
  always_comb begin
    for (int unsigned j = 0; j < DST_N; j++) begin
      elig[j] = msk_i[j] && (crd_q[j] != '0);
    end
  end

  assign rdy_o  = (|elig) && !rst;
  assign accept = vld_i && rdy_o;

  // Destination selection; only meaningful when some destination is eligible.
  always_comb begin
    logic             found;
    logic [CRD_W-1:0] best;
    int unsigned      r;
    found = 1'b0;
    best  = '0;
    sel   = '0;
    r     = 0;
    if (TYPE == "FSTR") begin
      // Later matches overwrite earlier ones: highest index wins.
      for (int unsigned j = 0; j < DST_N; j++) begin
        if (elig[j]) sel = DST_NW'(j);
      end
    end else if (TYPE == "RR") begin
      for (int unsigned k = 0; k < DST_N; k++) begin
        r = 32'(ptr_q) + k;
        if (r >= DST_N) r = r - DST_N;
        if (elig[r] && !found) begin
          sel   = DST_NW'(r);
          found = 1'b1;
        end
      end
    end else if (TYPE == "MAXC") begin
      // Strict greater-than keeps the lower index on ties.
      for (int unsigned j = 0; j < DST_N; j++) begin
        if (elig[j] && (!found || crd_q[j] > best)) begin
          sel   = DST_NW'(j);
          best  = crd_q[j];
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned j = 0; j < DST_N; j++) begin
        if (elig[j] && !found) begin
          sel   = DST_NW'(j);
          found = 1'b1;
        end
      end
    end
  end

  // Round-robin pointer advances past the chosen destination on accept only.
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      if (32'(sel) >= DST_N - 1) ptr_d = '0;
      else                       ptr_d = sel + 1'b1;
    end
  end

  always_comb begin
    vld_d = '0;
    if (accept) vld_d[sel] = 1'b1;
  end

  // Credit counters: simultaneous take and return cancel; returns saturate at full.
  always_comb begin
    logic dec, inc;
    err_d = err_q;
    dec   = 1'b0;
    inc   = 1'b0;
    for (int unsigned j = 0; j < DST_N; j++) begin
      dec      = accept && (32'(sel) == j);
      inc      = crd_rtn_i[j];
      crd_d[j] = crd_q[j];
      if (dec && !inc) begin
        crd_d[j] = crd_q[j] - 1'b1;
      end else if (inc && !dec) begin
        if (crd_q[j] == CRD_W'(CRD_MAX)) err_d    = 1'b1;
        else                              crd_d[j] = crd_q[j] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < DST_N; j++) crd_q[j] <= CRD_W'(CRD_MAX);
      ptr_q <= '0;
      vld_q <= '0;
      dat_q <= '0;
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < DST_N; j++) crd_q[j] <= crd_d[j];
      ptr_q <= ptr_d;
      vld_q <= vld_d;
      err_q <= err_d;
      if (accept) begin
        dat_q <= dat_i;
        idx_q <= sel;
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < DST_N; j++) crd_o[j*CRD_W +: CRD_W] = crd_q[j];
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;
  assign idx_o = idx_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_stl_dispatch.sv
// Directed bench for stl_dispatch: one instance per selection policy, shared clock/reset.
module tb_stl_dispatch;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  // FSTL, default 16 destinations
  logic        a_vld, a_rdy, a_err;
  logic [31:0] a_dat, a_dat_o;
  logic [15:0] a_msk, a_vld_o, a_rtn;
  logic [3:0]  a_idx;
  logic [47:0] a_crd;
  // RR / MAXC / FSTR, 4 destinations
  logic        r_vld, r_rdy, r_err, m_vld, m_rdy, m_err, h_vld, h_rdy, h_err;
  logic [31:0] r_dat, r_dat_o, m_dat, m_dat_o, h_dat, h_dat_o;
  logic [3:0]  r_msk, r_vld_o, r_rtn, m_msk, m_vld_o, m_rtn, h_msk, h_vld_o, h_rtn;
  logic [1:0]  r_idx, m_idx, h_idx;
  logic [11:0] r_crd, m_crd, h_crd;

  stl_dispatch #(.TYPE("FSTL")) u_a (
    .clk(clk), .rst(rst), .vld_i(a_vld), .rdy_o(a_rdy), .dat_i(a_dat), .msk_i(a_msk),
    .vld_o(a_vld_o), .dat_o(a_dat_o), .idx_o(a_idx), .crd_rtn_i(a_rtn), .crd_o(a_crd),
    .err_o(a_err)
  );
  stl_dispatch #(.TYPE("RR"), .DST_N(4), .DST_NW(2)) u_r (
    .clk(clk), .rst(rst), .vld_i(r_vld), .rdy_o(r_rdy), .dat_i(r_dat), .msk_i(r_msk),
    .vld_o(r_vld_o), .dat_o(r_dat_o), .idx_o(r_idx), .crd_rtn_i(r_rtn), .crd_o(r_crd),
    .err_o(r_err)
  );
  stl_dispatch #(.TYPE("MAXC"), .DST_N(4), .DST_NW(2)) u_m (
    .clk(clk), .rst(rst), .vld_i(m_vld), .rdy_o(m_rdy), .dat_i(m_dat), .msk_i(m_msk),
    .vld_o(m_vld_o), .dat_o(m_dat_o), .idx_o(m_idx), .crd_rtn_i(m_rtn), .crd_o(m_crd),
    .err_o(m_err)
  );
  stl_dispatch #(.TYPE("FSTR"), .DST_N(4), .DST_NW(2)) u_h (
    .clk(clk), .rst(rst), .vld_i(h_vld), .rdy_o(h_rdy), .dat_i(h_dat), .msk_i(h_msk),
    .vld_o(h_vld_o), .dat_o(h_dat_o), .idx_o(h_idx), .crd_rtn_i(h_rtn), .crd_o(h_crd),
    .err_o(h_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  logic [47:0] full16;
  int unsigned exp_idx;

  initial begin
    {a_vld, a_dat, a_msk, a_rtn} = '0;
    {r_vld, r_dat, r_msk, r_rtn} = '0;
    {m_vld, m_dat, m_msk, m_rtn} = '0;
    {h_vld, h_dat, h_msk, h_rtn} = '0;
    for (int j = 0; j < 16; j++) full16[j*3 +: 3] = 3'd4;

    // ---- reset state, ready low while in reset ----
    a_msk = 16'hffff;
    rst   = 1'b1;
    #1;
    check("rdy_in_rst", 64'(a_rdy), 64'd0);
    tick();
    rst = 1'b0;
    check("rst_vld", 64'(a_vld_o), 64'd0);
    check("rst_dat", 64'(a_dat_o), 64'd0);
    check("rst_idx", 64'(a_idx), 64'd0);
    check("rst_err", 64'(a_err), 64'd0);
    check("rst_crd", 64'(a_crd), 64'(full16));
    check("rst_crd_rr", 64'(r_crd), 64'h924);

    // ---- FSTL: 5 back-to-back items, all destinations allowed ----
    a_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_dat = 32'(100 + i);
      #1;
      check("fstl_rdy", 64'(a_rdy), 64'd1);
      tick();
      exp_idx = (i < 4) ? 0 : 1;
      check("fstl_vld", 64'(a_vld_o), 64'(16'd1 << exp_idx));
      check("fstl_idx", 64'(a_idx), 64'(exp_idx));
      check("fstl_dat", 64'(a_dat_o), 64'(100 + i));
    end
    a_vld = 1'b0;
    tick();
    check("fstl_idle_vld", 64'(a_vld_o), 64'd0);
    check("fstl_hold_dat", 64'(a_dat_o), 64'd104);
    check("fstl_hold_idx", 64'(a_idx), 64'd1);
    check("fstl_crd0", 64'(a_crd[2:0]), 64'd0);
    check("fstl_crd1", 64'(a_crd[5:3]), 64'd3);

    // ---- empty mask stalls with no error ----
    a_vld = 1'b1;
    a_msk = 16'h0000;
    #1;
    check("msk0_rdy", 64'(a_rdy), 64'd0);
    tick();
    check("msk0_vld", 64'(a_vld_o), 64'd0);
    check("msk0_err", 64'(a_err), 64'd0);

    // ---- starvation on destination 0, then one credit returned ----
    a_msk = 16'h0001;
    a_dat = 32'hcafe;
    #1;
    check("starve_rdy", 64'(a_rdy), 64'd0);
    a_rtn = 16'h0001;
    tick();
    a_rtn = 16'h0000;
    check("starve_vld", 64'(a_vld_o), 64'd0);
    check("ret_rdy", 64'(a_rdy), 64'd1);
    tick();
    a_vld = 1'b0;
    check("ret_vld", 64'(a_vld_o), 64'd1);
    check("ret_dat", 64'(a_dat_o), 64'hcafe);
    check("ret_crd0", 64'(a_crd[2:0]), 64'd0);
    #1;
    check("ret_rdy_after", 64'(a_rdy), 64'd0);

    // ---- dec only, then dec and return together on destination 1 ----
    a_vld = 1'b1;
    a_msk = 16'h0002;
    tick();
    check("dec_crd1", 64'(a_crd[5:3]), 64'd2);
    a_rtn = 16'h0002;
    tick();
    a_rtn = 16'h0000;
    a_vld = 1'b0;
    check("both_idx", 64'(a_idx), 64'd1);
    check("both_crd1", 64'(a_crd[5:3]), 64'd2);
    check("both_err", 64'(a_err), 64'd0);

    // ---- return into a full counter saturates and sets sticky error ----
    a_rtn = 16'h0004;
    tick();
    a_rtn = 16'h0000;
    check("sat_crd2", 64'(a_crd[8:6]), 64'd4);
    check("sat_err", 64'(a_err), 64'd1);
    tick();
    tick();
    check("err_sticky", 64'(a_err), 64'd1);

    // ---- RR over mask 1011, each used destination drains the cycle after ----
    do_reset();
    check("err_cleared", 64'(a_err), 64'd0);
    r_vld = 1'b1;
    r_msk = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      r_rtn = r_vld_o;
      tick();
      exp_idx = (i % 3 == 2) ? 3 : (i % 3);
      check("rr_idx", 64'(r_idx), 64'(exp_idx));
      check("rr_vld", 64'(r_vld_o), 64'(4'd1 << exp_idx));
    end
    r_rtn = 4'b0100;  // destination 2 is full: sets the error
    tick();           // accept to 0, pointer moves to 1
    r_rtn = 4'b0000;
    check("rr_wrap_idx", 64'(r_idx), 64'd0);
    check("rr_err_set", 64'(r_err), 64'd1);
    // reset the cycle after an accept, with a new item still offered
    rst = 1'b1;
    #1;
    check("rr_rst_rdy", 64'(r_rdy), 64'd0);
    tick();
    rst = 1'b0;
    check("rr_rst_vld", 64'(r_vld_o), 64'd0);
    check("rr_rst_crd", 64'(r_crd), 64'h924);
    check("rr_rst_err", 64'(r_err), 64'd0);
    r_msk = 4'b1111;
    tick();
    r_vld = 1'b0;
    check("rr_rst_ptr", 64'(r_idx), 64'd0);

    // ---- MAXC: preset credits to {1,4,2,4} for destinations 0..3 ----
    do_reset();
    m_vld = 1'b1;
    m_msk = 4'b0001;
    tick();
    tick();
    tick();
    m_msk = 4'b0100;
    tick();
    tick();
    m_vld = 1'b0;
    check("maxc_preset", 64'(m_crd), 64'h8a1);
    m_vld = 1'b1;
    m_msk = 4'b1111;
    tick();
    check("maxc_tie_low", 64'(m_idx), 64'd1);
    check("maxc_crd_a", 64'(m_crd), 64'h899);
    tick();
    m_vld = 1'b0;
    check("maxc_next", 64'(m_idx), 64'd3);
    check("maxc_crd_b", 64'(m_crd), 64'h699);

    // ---- FSTR: highest eligible index ----
    h_vld = 1'b1;
    h_msk = 4'b0110;
    tick();
    check("fstr_idx_a", 64'(h_idx), 64'd2);
    h_msk = 4'b1111;
    tick();
    h_vld = 1'b0;
    check("fstr_idx_b", 64'(h_idx), 64'd3);
    check("fstr_crd", 64'(h_crd), 64'h6e4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
